// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and its consumers.
// The generator side takes the advance enable and drives sync, video and coordinates.
interface vga_timing_gen_if;
  logic       ce;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       frame_tick;

  modport master (
    input  ce,
    output hsync, vsync, video_on, pix_x, pix_y, frame_tick
  );

  modport slave (
    output ce,
    input  hsync, vsync, video_on, pix_x, pix_y, frame_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parameterised raster timing generator (default 640x480 @ 60 Hz on a 25 MHz pixel clock).
// Counters form the first stage; sync/video/coordinate outputs are registered one enabled clock later.
module vga_timing_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Compares run at 11 bits so a sync end of exactly 1024 stays representable.
  localparam logic [10:0] H_VIS_C  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_BEG_C = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END_C = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] H_LAST_C = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_VIS_C  = 11'(V_VISIBLE);
  localparam logic [10:0] VS_BEG_C = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END_C = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [10:0] V_LAST_C = 11'(V_TOTAL - 1);

  logic [9:0]  h_cnt_p0, v_cnt_p0;
  logic [10:0] h_ext_p0, v_ext_p0;
  logic        h_wrap_p0, v_wrap_p0;
  logic        vis_p0, hs_act_p0, vs_act_p0, origin_p0;

  logic        hsync_p1, vsync_p1, video_on_p1, frame_tick_p1;
  logic [9:0]  pix_x_p1, pix_y_p1;

  // Stage p0: raster counters and combinational decode of the current position
  assign h_ext_p0  = {1'b0, h_cnt_p0};
  assign v_ext_p0  = {1'b0, v_cnt_p0};
  // >= rather than == lets an out-of-range count recover on the next enabled edge.
  assign h_wrap_p0 = (h_ext_p0 >= H_LAST_C);
  assign v_wrap_p0 = (v_ext_p0 >= V_LAST_C);
  assign vis_p0    = (h_ext_p0 < H_VIS_C) && (v_ext_p0 < V_VIS_C);
  assign hs_act_p0 = (h_ext_p0 >= HS_BEG_C) && (h_ext_p0 < HS_END_C);
  assign vs_act_p0 = (v_ext_p0 >= VS_BEG_C) && (v_ext_p0 < VS_END_C);
  assign origin_p0 = (h_cnt_p0 == 10'd0) && (v_cnt_p0 == 10'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_p0 <= 10'd0;
      v_cnt_p0 <= 10'd0;
    end else if (vga.ce) begin
      h_cnt_p0 <= h_wrap_p0 ? 10'd0 : h_cnt_p0 + 10'd1;
      if (h_wrap_p0) begin
        v_cnt_p0 <= v_wrap_p0 ? 10'd0 : v_cnt_p0 + 10'd1;
      end
    end
  end

  // Stage p1: registered outputs, one enabled clock behind the counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_p1    <= ~SYNC_POL;
      vsync_p1    <= ~SYNC_POL;
      video_on_p1 <= 1'b0;
      pix_x_p1    <= 10'd0;
      pix_y_p1    <= 10'd0;
    end else if (vga.ce) begin
      hsync_p1    <= hs_act_p0 ? SYNC_POL : ~SYNC_POL;
      vsync_p1    <= vs_act_p0 ? SYNC_POL : ~SYNC_POL;
      video_on_p1 <= vis_p0;
      pix_x_p1    <= vis_p0 ? h_cnt_p0 : 10'd0;
      pix_y_p1    <= vis_p0 ? v_cnt_p0 : 10'd0;
    end
  end

  // The strobe reloads every clock so it can never stretch across a ce=0 edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_tick_p1 <= 1'b0;
    end else begin
      frame_tick_p1 <= vga.ce && origin_p0;
    end
  end

  assign vga.hsync      = hsync_p1;
  assign vga.vsync      = vsync_p1;
  assign vga.video_on   = video_on_p1;
  assign vga.pix_x      = pix_x_p1;
  assign vga.pix_y      = pix_y_p1;
  assign vga.frame_tick = frame_tick_p1;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that directly consumes the 25 MHz pixel clock produced by the clock divider.
- Produces HSYNC/VSYNC, a video-active flag, pixel coordinates and a start-of-frame strobe for the joystick-demo VGA display path.
- Defaults give 640x480 @ 60 Hz. All timing is parameterised so other modes reuse the block.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, HSYNC pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, VSYNC pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)

Ports:
- clk  in  1  pixel clock (clk_25mhz from clock_divider)
- rst  in  1  asynchronous, active-low reset (0 = reset)
- ce  in  1  advance enable; tie to 1 for one pixel per clk
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- video_on  out  1  high while the pixel is in the visible region
- pix_x  out  10  column 0..H_VISIBLE-1, 0 outside the visible region
- pix_y  out  10  row 0..V_VISIBLE-1, 0 outside the visible region
- frame_tick  out  1  one-clk pulse at start of frame (h=0, v=0)

Behaviour:
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Counter widths are 10 bits; parameters must keep H_TOTAL and V_TOTAL ≤ 1024.
- Internal counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1).
- Counter update on each rising clk edge with ce=1:
  - if h_cnt = H_TOTAL-1, h_cnt←0, else h_cnt←h_cnt+1;
  - when h_cnt wraps, v_cnt advances; when v_cnt = V_TOTAL-1 it wraps to 0.
- When ce=0, counters and all outputs except frame_tick hold.
- Decode, combinational on the current counters:
  - vis = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE)
  - hs_act = H_VISIBLE+H_FRONT ≤ h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751)
  - vs_act = V_VISIBLE+V_FRONT ≤ v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491)
- Output registers load on a rising edge with ce=1, so outputs lag counter state by exactly one enabled clock:
  - hsync ← hs_act ? SYNC_POL : ~SYNC_POL; vsync likewise from vs_act;
  - video_on ← vis; pix_x ← vis ? h_cnt : 0; pix_y ← vis ? v_cnt : 0.
- frame_tick:
  - set on a ce=1 edge where h_cnt=0 and v_cnt=0;
  - cleared on the next clk edge regardless of ce, so it is never wider than one clk.
- Reset (rst=0, asynchronous, takes effect immediately without a clock edge):
  - h_cnt=0, v_cnt=0, video_on=0, pix_x=0, pix_y=0, frame_tick=0;
  - hsync = vsync = ~SYNC_POL (deasserted).
- Reset mid-frame: outputs return to reset values at once. The first enabled edge after release decodes (0,0), so frame_tick pulses and video_on rises on that edge.
- Reset release: synchronous to the clock. rst must be high for one full clk period before the first counting edge; no metastability handling is done inside the block.
- vsync changes only in the same output update as an h_cnt wrap, i.e. aligned to line start.
- No illegal counter states are reachable. If a counter ever exceeds its total, the next enabled edge wraps it to 0.

Test Plan:
- Reset check: hold rst=0, toggle clk, ce=1 → hsync=1, vsync=1, video_on=0, pix_x=pix_y=0, frame_tick=0. Assert rst=0 asynchronously mid-cycle → outputs reset before the next edge.
- Line timing: release rst with ce=1 → frame_tick high for exactly 1 clk after the 1st edge. video_on high for 640 consecutive clks, pix_x counting 0..639. hsync low for 96 clks starting 656 clks after video_on rises. Line period is 800 clks.
- Frame timing: run one full frame →
  - frame_tick period = 420000 clks;
  - video_on high on 480 lines;
  - vsync low for exactly 1600 clks, starting at the start of line 490;
  - pix_y = 479 on the last visible line, then pix_y = 0.
- Enable gating: ce toggled 1,0,1,0 → counters advance every 2nd clk. Line period becomes 1600 clks. frame_tick stays 1 clk wide; the other outputs hold while ce=0.
- Reset mid-operation: pulse rst=0 at line 300, pixel 200 → immediate reset values. On release, frame_tick pulses and pix_x restarts at 0 on line 0.
- Parameter override: H_VISIBLE=8, H_FRONT=2, H_SYNC=3, H_BACK=3, V_VISIBLE=4, V_FRONT=1, V_SYNC=1, V_BACK=2 → line = 16 clks, hsync low for 3 clks after 10 clks, frame = 128 clks. Repeat with SYNC_POL=1 → sync pulses become active-high.
